// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants and the scoreboard entry layout for the decode-stage hazard unit.
// Consumed by id_hazard_scoreboard and id_fwd_port.
package id_pkg;

  localparam int ID_AW    = 5;
  localparam int ID_DW    = 32;
  localparam int ID_DEPTH = 3;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  // Entry layout for the default configuration; the top rebuilds it per-field for other widths.
  typedef struct packed {
    logic             valid;
    logic [ID_AW-1:0] waddr;
    logic [1:0]       ready_slot;
  } id_entry_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Decode-stage operand bus between the ID stage (master) and the hazard scoreboard (slave).
interface id_hazard_scoreboard_if #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 3
);
  logic                hold;
  logic                flush;
  logic                issue_valid;
  logic                issue_we;
  logic [AW-1:0]       issue_waddr;
  logic                issue_load;
  logic                rs_used;
  logic [AW-1:0]       rs_addr;
  logic                rt_used;
  logic [AW-1:0]       rt_addr;
  logic [DW-1:0]       rf_rdata1;
  logic [DW-1:0]       rf_rdata2;
  logic [DEPTH*DW-1:0] slot_wdata;
  logic [DW-1:0]       rs_data;
  logic [DW-1:0]       rt_data;
  logic                stallreq;

  // Handshake: the ID instruction is accepted into slot0 on a rising edge exactly when
  // issue_valid & !stallreq & !flush & !hold; stallreq is the (inverted) ready, same cycle.
  modport master (
    output hold, flush, issue_valid, issue_we, issue_waddr, issue_load,
    output rs_used, rs_addr, rt_used, rt_addr, rf_rdata1, rf_rdata2, slot_wdata,
    input  rs_data, rt_data, stallreq
  );

  modport slave (
    input  hold, flush, issue_valid, issue_we, issue_waddr, issue_load,
    input  rs_used, rs_addr, rt_used, rt_addr, rf_rdata1, rf_rdata2, slot_wdata,
    output rs_data, rt_data, stallreq
  );
endinterface

// File: rtl/id_hazard_scoreboard_fwd_port.sv
// One operand read port: youngest-match scan, forward mux and hazard bit.
// ID_FWD_EN selects forwarding; without it any match short of WB is a hazard.
module id_fwd_port
  import id_pkg::*;
#(
  parameter int AW    = ID_AW,
  parameter int DW    = ID_DW,
  parameter int DEPTH = ID_DEPTH,
  parameter int SW    = 2
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] waddr_i,
  input  logic [DEPTH-1:0][SW-1:0] rdy_i,
  input  logic                     used_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DW-1:0]            rf_rdata_i,
  input  logic [DEPTH*DW-1:0]      slot_wdata_i,
  output logic [DW-1:0]            data_o,
  output logic                     hazard_o
);

`ifndef ID_FWD_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rdy_i, slot_wdata_i};
`endif

  always_comb begin
    logic found;
    found    = 1'b0;
    hazard_o = 1'b0;
    data_o   = rf_rdata_i;
    // Scan from the youngest slot; the first hit shadows every older producer.
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && used_i && (addr_i != '0) && valid_i[i] && (waddr_i[i] == addr_i)) begin
        found = 1'b1;
`ifdef ID_FWD_EN
        if (SW'(i) < rdy_i[i]) hazard_o = 1'b1;
        else                   data_o   = slot_wdata_i[i*DW +: DW];
`else
        if (i < DEPTH - 1) hazard_o = 1'b1;
`endif
      end
    end
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage hazard scoreboard: DEPTH-slot shift register of pending writes, two read ports.
// Optional forwarding is enabled with the ID_FWD_EN macro.
module id_hazard_scoreboard
  import id_pkg::*;
#(
  parameter int AW        = ID_AW,
  parameter int DW        = ID_DW,
  parameter int DEPTH     = ID_DEPTH,
  parameter int LOAD_SLOT = SLOT_MEM
) (
  input logic                   clk,
  input logic                   rst,
  id_hazard_scoreboard_if.slave bus
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] waddr_q, waddr_d;
  logic [DEPTH-1:0][SW-1:0] rdy_q,   rdy_d;
  logic                     haz_rs, haz_rt, stall, issue_ok;

  assign stall        = haz_rs | haz_rt;
  assign bus.stallreq = stall;
  assign issue_ok     = bus.issue_valid & bus.issue_we & (bus.issue_waddr != '0)
                      & ~stall & ~bus.flush;

  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    rdy_d   = rdy_q;
    if (!bus.hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        waddr_d[i] = waddr_q[i-1];
        rdy_d[i]   = rdy_q[i-1];
      end
      valid_d[0] = issue_ok;
      waddr_d[0] = bus.issue_waddr;
      rdy_d[0]   = bus.issue_load ? SW'(LOAD_SLOT) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      waddr_q <= '0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      rdy_q   <= rdy_d;
    end
  end

  id_fwd_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .SW(SW)) u_rs (
    .valid_i      (valid_q),
    .waddr_i      (waddr_q),
    .rdy_i        (rdy_q),
    .used_i       (bus.rs_used),
    .addr_i       (bus.rs_addr),
    .rf_rdata_i   (bus.rf_rdata1),
    .slot_wdata_i (bus.slot_wdata),
    .data_o       (bus.rs_data),
    .hazard_o     (haz_rs)
  );

  id_fwd_port #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .SW(SW)) u_rt (
    .valid_i      (valid_q),
    .waddr_i      (waddr_q),
    .rdy_i        (rdy_q),
    .used_i       (bus.rt_used),
    .addr_i       (bus.rt_addr),
    .rf_rdata_i   (bus.rf_rdata2),
    .slot_wdata_i (bus.slot_wdata),
    .data_o       (bus.rt_data),
    .hazard_o     (haz_rt)
  );

endmodule
